simplelogic_pipe: RTL and testbench
===================================

Name: simplelogic_pipe

Overview:
- Parametrised, pipelined successor to the single-bit registered AND cell.
- Applies one of four bitwise operations (AND/OR/XOR/NAND) to two WIDTH-bit operands.
- Carries the result through STAGES elastic register stages with a valid/ready handshake, a global enable and a saturating output-transfer counter.
- Sits between an operand producer and any result consumer that can apply backpressure.

Parameters:
- WIDTH, 8: operand/result width in bits, legal range 1 or more.
- STAGES, 2: number of pipeline register stages (= latency), legal range 1 or more. STAGES<1 is an elaboration error.
- CNT_W, 16: width of the output transfer counter.

Ports:
- inclk  input  1  clock; all logic is rising-edge.
- inrst  input  1  reset; synchronous, active-high.
- inen  input  1  global enable; 0 freezes the whole block.
- invalid  input  1  upstream offers an operand pair this cycle.
- outaccept  output  1  block accepts the offered pair this cycle.
- ina  input  WIDTH  operand A.
- inb  input  WIDTH  operand B.
- inop  input  2  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND. Sampled with the operands.
- outy  output  WIDTH  result at the last stage.
- outvalid  output  1  outy holds a valid result.
- inready  input  1  downstream accepts the result this cycle.
- outcount  output  CNT_W  number of completed output transfers, saturating.

Behaviour:
- One clock (inclk). Reset inrst is synchronous and active-high.
- While inrst=1, at every clock edge:
  - all stage valid bits clear to 0;
  - all stage data clears to 0, so outy=0 and outvalid=0;
  - outcount clears to 0;
  - outaccept is held at 0 combinationally.
- Reset mid-operation discards all in-flight results. outvalid=0 from the first edge with inrst=1.
- Function: the stage-0 input is f(ina, inb, inop), computed combinationally and registered into stage 0 on acceptance.
- Accept condition: outaccept = inen and not inrst and (stage 0 empty or stage 0 advancing).
- Input transfer: invalid and outaccept. Stage 0 loads data, valid=1.
- Stage k advances when inen=1, stage k is valid, and stage k+1 is empty or advancing.
- The last stage advances when outvalid and inready (output transfer).
- Stage k becomes empty when it advances and nothing loads into it in the same cycle.
- Simultaneous drain and fill of the same stage in one cycle is a load: no bubble inserted.
- A stage that is not advancing holds its data and valid bit; data is never overwritten while valid.
- Latency: with inready=1 and inen=1, a pair accepted at edge N appears with outvalid=1 after edge N+STAGES-1. Output transfer occurs at edge N+STAGES.
- Throughput is 1 pair per cycle when unstalled. Capacity is STAGES results.
- Ordering: results leave in acceptance order. No loss, no duplication.
- outy is don't-care when outvalid=0, but holds the last stage register (0 after reset).
- inen=0:
  - outaccept=0;
  - no stage advances; all registers, including outcount, hold;
  - outvalid and outy stay as they were, but no output transfer is counted even if inready=1.
- inen applies on the same cycle it is sampled.
- outcount increments by 1 on each output transfer (outvalid and inready and inen). It saturates at 2^CNT_W-1 and never wraps.
- The upstream may drop invalid without penalty. inop/ina/inb are sampled only on an input transfer.

Optional Feature:
- Macro: SIMPLELOGIC_PIPE_PARITY_EN.
- When defined:
  - extra output port outparity (1 bit) is present;
  - it equals the XOR-reduction of the stage-0 result and travels with the data through every stage, so it is always aligned with outy;
  - it resets to 0 and holds under stall and inen=0.
- When undefined: the port and its registers do not exist. All other behaviour is identical.

Test Plan (WIDTH=8, STAGES=2 unless stated):
1. Reset: hold inrst=1 for 2 edges with invalid=1 and inen=1 -> outaccept=0, outvalid=0, outy=8'h00, outcount=0. Release -> outaccept=1 on the next cycle.
2. Ops: ina=8'hF0, inb=8'hCC, inop=0/1/2/3 on consecutive cycles, inready=1 -> outy=8'hC0, 8'hFC, 8'h3C, 8'h3F in order, each outvalid 2 edges after its accept. outcount=4. With the parity macro, outparity=0, 0, 0, 0.
3. Backpressure: inready=0, invalid=1 for 4 cycles -> exactly 2 accepts, then outaccept=0. Raise inready -> the 2 results exit in order on consecutive cycles, then the remaining offers are accepted. No duplicates. outcount counts only transfers.
4. Enable freeze: mid-stream, drop inen for 3 cycles with inready=1 -> outaccept=0, outy/outvalid/outcount unchanged. Restore inen -> the stream resumes with no lost or repeated result.
5. Saturation: CNT_W=2, perform 5 output transfers -> outcount reads 1, 2, 3, 3, 3.
6. Reset mid-stream: with 2 valid results in flight, assert inrst for 1 edge -> outvalid=0 and outcount=0 after that edge, and none of the in-flight results ever appear.

Source files
------------

// File: rtl/simplelogic_pipe.sv
// simplelogic_pipe: bitwise op unit feeding an elastic valid/ready pipeline.
// Optional macro SIMPLELOGIC_PIPE_PARITY_EN adds an aligned outparity port.
module simplelogic_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             inclk,
   input  logic             inrst,
   input  logic             inen,
   input  logic             invalid,
   output logic             outaccept,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic [1:0]       inop,
   output logic [WIDTH-1:0] outy,
   output logic             outvalid,
   input  logic             inready,
   output logic [CNT_W-1:0] outcount
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
   ,
   output logic             outparity
`endif
);

   generate
      if (STAGES < 1) begin : g_bad_stages
         $error("simplelogic_pipe: STAGES must be >= 1");
      end
   endgenerate

   localparam int L = STAGES - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]  data [STAGES];
   logic [WIDTH-1:0]  din  [STAGES];
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] ld;
   logic [WIDTH-1:0]  fres;
   logic [CNT_W-1:0]  cnt;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
   logic [STAGES-1:0] par;
   logic [STAGES-1:0] pin;
`endif

   // operand function selected by inop
   always_comb begin
      fres = '0;
      unique case (inop)
         2'd0: fres = ina & inb;
         2'd1: fres = ina | inb;
         2'd2: fres = ina ^ inb;
         2'd3: fres = ~(ina & inb);
      endcase
   end

   // advance chain resolved from the output back to stage 0
   always_comb begin
      logic go;
      adv = '0;
      go  = inen & inready;
      for (int k = L; k >= 0; k--) begin
         adv[k] = vld[k] & go;
         go     = inen & (~vld[k] | adv[k]);
      end
   end

   assign outaccept = inen & ~inrst & (~vld[0] | adv[0]);

   // per-stage load enables and incoming data
   always_comb begin
      ld     = '0;
      din[0] = fres;
      ld[0]  = invalid & outaccept;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
      pin    = '0;
      pin[0] = ^fres;
`endif
      for (int k = 1; k < STAGES; k++) begin
         ld[k]  = adv[k-1];
         din[k] = data[k-1];
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
         pin[k] = par[k-1];
`endif
      end
   end

   // stage registers: load wins over drain, otherwise hold
   always_ff @(posedge inclk) begin
      if (inrst) begin
         vld <= '0;
         for (int k = 0; k < STAGES; k++) data[k] <= '0;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
         par <= '0;
`endif
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
               data[k] <= din[k];
               vld[k]  <= 1'b1;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
               par[k]  <= pin[k];
`endif
            end else if (adv[k]) begin
               vld[k] <= 1'b0;
            end
         end
      end
   end

   // saturating count of output transfers
   always_ff @(posedge inclk) begin
      if (inrst)
         cnt <= '0;
      else if (adv[L] && cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   assign outy     = data[L];
   assign outvalid = vld[L];
   assign outcount = cnt;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
   assign outparity = par[L];
`endif

endmodule

// File: tb/tb_simplelogic_pipe.sv
// Directed testbench for simplelogic_pipe (WIDTH=8, STAGES=2).
// A second instance with CNT_W=2 shares the stimulus for saturation.
module tb_simplelogic_pipe;

   logic       clk = 1'b0;
   logic       inrst = 1'b1;
   logic       inen = 1'b1;
   logic       invalid = 1'b0;
   logic [7:0] ina = '0;
   logic [7:0] inb = '0;
   logic [1:0] inop = '0;
   logic       inready = 1'b0;
   logic       outaccept, outvalid;
   logic [7:0] outy;
   logic [15:0] outcount;
   logic       outaccept2, outvalid2;
   logic [7:0] outy2;
   logic [1:0] outcount2;
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
   logic       outparity, outparity2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   simplelogic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
      .inclk(clk), .inrst(inrst), .inen(inen), .invalid(invalid),
      .outaccept(outaccept), .ina(ina), .inb(inb), .inop(inop),
      .outy(outy), .outvalid(outvalid), .inready(inready),
      .outcount(outcount)
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
      , .outparity(outparity)
`endif
   );

   simplelogic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut2 (
      .inclk(clk), .inrst(inrst), .inen(inen), .invalid(invalid),
      .outaccept(outaccept2), .ina(ina), .inb(inb), .inop(inop),
      .outy(outy2), .outvalid(outvalid2), .inready(inready),
      .outcount(outcount2)
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
      , .outparity(outparity2)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      inrst = 1'b1; inen = 1'b1; invalid = 1'b1; inready = 1'b1;
      ina = 8'hAA; inb = 8'h55; inop = 2'd1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (outaccept !== 1'b0 || outvalid !== 1'b0 || outy !== 8'h00 ||
             outcount !== 16'd0) begin
            errors++;
            $display("FAIL reset: acc=%b vld=%b y=%h cnt=%0d, want 0 0 00 0",
                     outaccept, outvalid, outy, outcount);
         end
      end
      invalid = 1'b0;
      inrst = 1'b0;
      #1;
      checks++;
      if (outaccept !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: outaccept=%b, want 1", outaccept);
      end
   endtask

   task automatic test_ops();
      logic [7:0] exp [4];
      exp[0] = 8'hC0; exp[1] = 8'hFC; exp[2] = 8'h3C; exp[3] = 8'h3F;
      ina = 8'hF0; inb = 8'hCC; inready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         invalid = (i < 4);
         inop = 2'(i);
         #1;
         if (i < 4) begin
            checks++;
            if (outaccept !== 1'b1) begin
               errors++;
               $display("FAIL ops_accept[%0d]: got %b, want 1", i, outaccept);
            end
         end
         step();
         if (i >= 1 && i <= 4) begin
            checks++;
            if (outvalid !== 1'b1 || outy !== exp[i-1]) begin
               errors++;
               $display("FAIL ops_result[%0d]: vld=%b y=%h, want 1 %h",
                        i - 1, outvalid, outy, exp[i-1]);
            end
`ifdef SIMPLELOGIC_PIPE_PARITY_EN
            checks++;
            if (outparity !== 1'b0) begin
               errors++;
               $display("FAIL ops_parity[%0d]: got %b, want 0",
                        i - 1, outparity);
            end
`endif
         end
      end
      checks++;
      if (outvalid !== 1'b0 || outcount !== 16'd4) begin
         errors++;
         $display("FAIL ops_end: vld=%b cnt=%0d, want 0 4",
                  outvalid, outcount);
      end
   endtask

   task automatic test_backpressure();
      int nacc = 0;
      int nout = 0;
      inready = 1'b0; inop = 2'd1; inb = 8'h00;
      for (int i = 0; i < 4; i++) begin
         invalid = 1'b1;
         ina = 8'(8'h10 + nacc);
         #1;
         if (outaccept) nacc++;
         step();
      end
      checks++;
      if (nacc != 2 || outaccept !== 1'b0 || outcount !== 16'd4) begin
         errors++;
         $display("FAIL bp_stall: accepts=%0d acc=%b cnt=%0d, want 2 0 4",
                  nacc, outaccept, outcount);
      end
      inready = 1'b1;
      for (int c = 0; c < 12 && nout < 4; c++) begin
         if (outvalid) begin
            checks++;
            if (outy !== 8'(8'h10 + nout)) begin
               errors++;
               $display("FAIL bp_order[%0d]: got %h, want %h",
                        nout, outy, 8'(8'h10 + nout));
            end
            nout++;
         end
         invalid = (nacc < 4);
         ina = 8'(8'h10 + nacc);
         #1;
         if (invalid && outaccept) nacc++;
         step();
      end
      invalid = 1'b0;
      checks++;
      if (nout != 4 || outvalid !== 1'b0 || outcount !== 16'd8) begin
         errors++;
         $display("FAIL bp_drain: outs=%0d vld=%b cnt=%0d, want 4 0 8",
                  nout, outvalid, outcount);
      end
   endtask

   task automatic test_enable();
      int nacc = 2;
      int nout = 0;
      inready = 1'b1; inop = 2'd1; inb = 8'h00;
      invalid = 1'b1; ina = 8'h20;
      step();
      ina = 8'h21;
      step();
      inen = 1'b0;
      ina = 8'h22;
      #1;
      checks++;
      if (outaccept !== 1'b0) begin
         errors++;
         $display("FAIL en_accept: got %b, want 0", outaccept);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (outaccept !== 1'b0 || outvalid !== 1'b1 || outy !== 8'h20 ||
             outcount !== 16'd8) begin
            errors++;
            $display("FAIL en_freeze[%0d]: acc=%b vld=%b y=%h cnt=%0d, want 0 1 20 8",
                     i, outaccept, outvalid, outy, outcount);
         end
      end
      inen = 1'b1;
      for (int c = 0; c < 12 && nout < 4; c++) begin
         if (outvalid) begin
            checks++;
            if (outy !== 8'(8'h20 + nout)) begin
               errors++;
               $display("FAIL en_order[%0d]: got %h, want %h",
                        nout, outy, 8'(8'h20 + nout));
            end
            nout++;
         end
         invalid = (nacc < 4);
         ina = 8'(8'h20 + nacc);
         #1;
         if (invalid && outaccept) nacc++;
         step();
      end
      invalid = 1'b0;
      checks++;
      if (nout != 4 || outvalid !== 1'b0 || outcount !== 16'd12) begin
         errors++;
         $display("FAIL en_resume: outs=%0d vld=%b cnt=%0d, want 4 0 12",
                  nout, outvalid, outcount);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp;
      inrst = 1'b1;
      step();
      inrst = 1'b0;
      checks++;
      if (outcount2 !== 2'd0) begin
         errors++;
         $display("FAIL sat_reset: got %0d, want 0", outcount2);
      end
      inready = 1'b1; inop = 2'd2; ina = 8'h0F; inb = 8'h01;
      for (int i = 0; i < 7; i++) begin
         invalid = (i < 5);
         step();
         if (i >= 2) begin
            exp = (i - 1 > 3) ? 2'd3 : 2'(i - 1);
            checks++;
            if (outcount2 !== exp) begin
               errors++;
               $display("FAIL sat_count[%0d]: got %0d, want %0d",
                        i - 1, outcount2, exp);
            end
         end
      end
      invalid = 1'b0;
      checks++;
      if (outcount !== 16'd5) begin
         errors++;
         $display("FAIL sat_wide: got %0d, want 5", outcount);
      end
   endtask

   task automatic test_reset_midstream();
      inready = 1'b0; inop = 2'd1; inb = 8'h00;
      invalid = 1'b1; ina = 8'h55;
      step();
      ina = 8'h66;
      step();
      invalid = 1'b0;
      checks++;
      if (outvalid !== 1'b1 || outy !== 8'h55) begin
         errors++;
         $display("FAIL mid_fill: vld=%b y=%h, want 1 55", outvalid, outy);
      end
      inrst = 1'b1;
      step();
      checks++;
      if (outvalid !== 1'b0 || outcount !== 16'd0 || outy !== 8'h00 ||
          outaccept !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: vld=%b cnt=%0d y=%h acc=%b, want 0 0 00 0",
                  outvalid, outcount, outy, outaccept);
      end
      inrst = 1'b0;
      inready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (outvalid !== 1'b0 || outcount !== 16'd0) begin
            errors++;
            $display("FAIL mid_ghost[%0d]: vld=%b y=%h cnt=%0d, want 0 - 0",
                     i, outvalid, outy, outcount);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_enable();
      test_saturation();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
